// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the memory-mapped GPIO responder.
//   Register offsets inside the 32-byte window.
//   Bus-handshake FSM state encoding.
package gpio_pkg;

  localparam logic [4:0] OFF_OUT  = 5'h00;
  localparam logic [4:0] OFF_IN   = 5'h04;
  localparam logic [4:0] OFF_STAT = 5'h08;
  localparam logic [4:0] OFF_MASK = 5'h0C;
  localparam logic [4:0] OFF_TGL  = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: two-flop synchroniser for asynchronous pin inputs, followed
// by one delay flop used to detect rising edges of the synchronised value.
// Ports:
//   clk     in   1           posedge clock
//   reset   in   1           synchronous, active-high; clears all flops
//   d       in   GPIO_WIDTH  asynchronous pin inputs
//   q_sync  out  GPIO_WIDTH  synchronised inputs (2 edges after a change on d)
//   rise    out  GPIO_WIDTH  one-cycle pulse per bit on a 0->1 of q_sync
module gpio_sync_edge #(
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [GPIO_WIDTH-1:0] d,
  output logic [GPIO_WIDTH-1:0] q_sync,
  output logic [GPIO_WIDTH-1:0] rise
);

  logic [GPIO_WIDTH-1:0] r_s1;
  logic [GPIO_WIDTH-1:0] r_s2;
  logic [GPIO_WIDTH-1:0] r_s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign q_sync = r_s2;
  // A held-high level gives s2 == s3, so only the first cycle after a 0->1 pulses.
  assign rise   = r_s2 & ~r_s3;

endmodule

// File: rtl/gpio_mmio_responder.sv
// gpio_mmio_responder: memory-mapped GPIO peripheral on the core data bus.
// Decodes a 32-byte window at BASE_ADDR, drives gpio_out, captures rising edges
// of the synchronised gpio_in into a sticky W1C status register and raises a
// registered level interrupt from the masked status.
// Ports:
//   clk        in   1           posedge clock
//   reset      in   1           synchronous, active-high
//   bus_req    in   1           request valid, held until bus_ack
//   bus_we     in   1           1 = store, 0 = load
//   bus_addr   in   32          byte address
//   bus_wdata  in   32          store data (low GPIO_WIDTH bits used)
//   bus_rdata  out  32          load data in the ack cycle, 0 otherwise
//   bus_ack    out  1           one-cycle response pulse
//   bus_err    out  1           misaligned access, qualifies bus_ack
//   gpio_in    in   GPIO_WIDTH  asynchronous pin inputs
//   gpio_out   out  GPIO_WIDTH  registered pin outputs
//   irq        out  1           registered |(EDGE_STAT & EDGE_MASK)
module gpio_mmio_responder
  import gpio_pkg::*;
#(
  parameter logic [31:0]           BASE_ADDR  = 32'h1001_0000,
  parameter int                    GPIO_WIDTH = 8,
  parameter logic [GPIO_WIDTH-1:0] RESET_OUT  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_req,
  input  logic                  bus_we,
  input  logic [31:0]           bus_addr,
  input  logic [31:0]           bus_wdata,
  output logic [31:0]           bus_rdata,
  output logic                  bus_ack,
  output logic                  bus_err,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  irq
);

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_sel;
  logic                  w_accept;
  logic                  w_misal;
  logic                  w_wr;
  logic [4:0]            w_off;
  logic [GPIO_WIDTH-1:0] w_wdata;
  logic [GPIO_WIDTH-1:0] w_in_sync;
  logic [GPIO_WIDTH-1:0] w_rise;
  logic [GPIO_WIDTH-1:0] w_clr;
  logic [31:0]           w_rd_data;
  logic                  w_unused_wdata;

  logic [GPIO_WIDTH-1:0] r_out;
  logic [GPIO_WIDTH-1:0] r_stat;
  logic [GPIO_WIDTH-1:0] r_mask;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  r_irq;

  gpio_sync_edge #(
    .GPIO_WIDTH(GPIO_WIDTH)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (gpio_in),
    .q_sync (w_in_sync),
    .rise   (w_rise)
  );

  // Decode: the access itself happens on the edge that moves IDLE -> RESP.
  assign w_sel    = bus_req & (bus_addr[31:5] == BASE_ADDR[31:5]);
  assign w_accept = (r_state == ST_IDLE) & w_sel;
  assign w_misal  = |bus_addr[1:0];
  assign w_off    = bus_addr[4:0];
  assign w_wdata  = bus_wdata[GPIO_WIDTH-1:0];
  assign w_wr     = w_accept & bus_we & ~w_misal;
  assign w_clr    = (w_wr && (w_off == OFF_STAT)) ? w_wdata : '0;

  // Only the low GPIO_WIDTH bits of store data matter.
  assign w_unused_wdata = ^bus_wdata;

  always_comb begin
    w_rd_data = '0;
    case (w_off)
      OFF_OUT:  w_rd_data = 32'(r_out);
      OFF_IN:   w_rd_data = 32'(w_in_sync);
      OFF_STAT: w_rd_data = 32'(r_stat);
      OFF_MASK: w_rd_data = 32'(r_mask);
      default:  w_rd_data = '0;
    endcase
  end

  // WAIT swallows a request still held high in the ack cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_sel) w_state_next = ST_RESP;
      ST_RESP: w_state_next = ST_WAIT;
      ST_WAIT: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_out   <= RESET_OUT;
      r_stat  <= '0;
      r_mask  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_rdata <= (!bus_we && !w_misal) ? w_rd_data : '0;
        r_err   <= w_misal;
      end
      if (w_wr && (w_off == OFF_OUT)) begin
        r_out <= w_wdata;
      end else if (w_wr && (w_off == OFF_TGL)) begin
        r_out <= r_out ^ w_wdata;
      end
      if (w_wr && (w_off == OFF_MASK)) begin
        r_mask <= w_wdata;
      end
      // A rise in the same cycle as a W1C on that bit keeps the flag set.
      r_stat <= (r_stat & ~w_clr) | w_rise;
      r_irq  <= |(r_stat & r_mask);
    end
  end

  // Reset during the RESP cycle suppresses the response.
  assign bus_ack   = (r_state == ST_RESP) & ~reset;
  assign bus_err   = bus_ack & r_err;
  assign bus_rdata = bus_ack ? r_rdata : '0;
  assign gpio_out  = r_out;
  assign irq       = r_irq;

endmodule
